regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module  : regfile_scoreboard
// Brief   : 2R/2W register file with write-to-read bypass and busy scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int c_DEPTH = 1 << ADDR_W;
  localparam int c_CNT_W = ADDR_W + 1;
  localparam bit c_ZERO  = (ZERO_REG != 0);

  logic [DATA_W-1:0]  r_regFile [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;
  logic [ADDR_W:0]    r_busyCnt;

  logic               w_we0;
  logic               w_we1;
  logic               w_iss;
  logic               w_set;
  logic               w_clr0;
  logic               w_clr1;
  logic [c_DEPTH-1:0] w_busyNext;
  logic [ADDR_W:0]    w_cntNext;

  // Hardwired zero register swallows writes and issues before they reach state.
  assign w_we0 = wr_en0 && !(c_ZERO && (wr_addr0 == '0));
  assign w_we1 = wr_en1 && !(c_ZERO && (wr_addr1 == '0));
  assign w_iss = iss_en && !(c_ZERO && (iss_addr == '0));

  always_comb begin
    w_busyNext = r_busy;
    if (w_we0) w_busyNext[wr_addr0] = 1'b0;
    if (w_we1) w_busyNext[wr_addr1] = 1'b0;
    if (w_iss) w_busyNext[iss_addr] = 1'b1;
  end

  // Each bit that actually flips is counted once; a dual write to one
  // address is credited to port 0 only.
  assign w_set  = w_iss && !r_busy[iss_addr];
  assign w_clr0 = w_we0 && r_busy[wr_addr0] && !(w_iss && (iss_addr == wr_addr0));
  assign w_clr1 = w_we1 && r_busy[wr_addr1] && !(w_iss && (iss_addr == wr_addr1))
                  && !(w_we0 && (wr_addr0 == wr_addr1));

  assign w_cntNext = r_busyCnt + c_CNT_W'(w_set) - c_CNT_W'(w_clr0) - c_CNT_W'(w_clr1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) r_regFile[i] <= '0;
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      // Port 1 is assigned last so it wins a same-address collision.
      if (w_we0) r_regFile[wr_addr0] <= wr_data0;
      if (w_we1) r_regFile[wr_addr1] <= wr_data1;
      r_busy    <= w_busyNext;
      r_busyCnt <= w_cntNext;
    end
  end

  always_comb begin
    rd_data1 = r_regFile[rd_addr1];
    if (w_we0 && (wr_addr0 == rd_addr1)) rd_data1 = wr_data0;
    if (w_we1 && (wr_addr1 == rd_addr1)) rd_data1 = wr_data1;
    rd_busy1 = r_busy[rd_addr1]
               && !(w_we0 && (wr_addr0 == rd_addr1))
               && !(w_we1 && (wr_addr1 == rd_addr1));
    if (c_ZERO && (rd_addr1 == '0)) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end
  end

  always_comb begin
    rd_data2 = r_regFile[rd_addr2];
    if (w_we0 && (wr_addr0 == rd_addr2)) rd_data2 = wr_data0;
    if (w_we1 && (wr_addr1 == rd_addr2)) rd_data2 = wr_data1;
    rd_busy2 = r_busy[rd_addr2]
               && !(w_we0 && (wr_addr0 == rd_addr2))
               && !(w_we1 && (wr_addr1 == rd_addr2));
    if (c_ZERO && (rd_addr2 == '0)) begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
    end
  end

  assign busy_cnt = r_busyCnt;

endmodule

`default_nettype wire
